sd_clk_gen: RTL and testbench
=============================

# sd_clk_gen

Parametrised Avalon-MM clock-generator peripheral driving the SD card clock line. It replaces the single-bit software-toggled output port with a hardware half-period divider, finite pulse bursts and a free-running mode. Software still has a static manual level for bit-banged init sequences. It sits on the Qsys system bus beside the SD command and data PIOs; `out_port` goes to the SD_CLK pin.

## Interface
- `DIV_W`, default 16: width of the divider register; half-period = DIV+1 clk cycles.
- `CNT_W`, default 16: width of the burst pulse counter; max burst 2^CNT_W−1 pulses.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  2  register select.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe. Write occurs when chipselect && !write_n.
- `writedata`  in  32  write data; upper unused bits ignored.
- `readdata`  out  32  combinational read data, zero wait states; unused bits read 0.
- `out_port`  out  1  registered SD clock output.
- `busy`  out  1  high while a burst or free-run is active.
- `irq`  out  1  level interrupt: done & irq_en.

## Operation
- Register 0, CTRL (rw, reset 0):
  - bit0 `level`: static output when idle.
  - bit1 `free_run`.
  - bit2 `irq_en`.
- Register 1, DIV (rw, DIV_W bits, reset 0): half-period minus one.
- Register 2, COUNT:
  - Write N≠0: loads remaining = N and starts a burst if idle.
  - Write 0: aborts.
  - Read returns remaining pulses.
- Register 3, STATUS:
  - bit0 `busy` (ro).
  - bit1 `done` (sticky; write 1 clears).
- FSM states IDLE, LOW, HIGH; reset state IDLE.
  - IDLE: out_port = level. A COUNT write N≠0, or free_run=1, goes to LOW and reloads the half-period counter.
  - LOW: out_port=0. At counter expiry goes to HIGH.
  - HIGH: out_port=1. At counter expiry:
    - Burst mode: remaining decrements. If the result is 0, go to IDLE and set done. Otherwise go to LOW.
    - free_run=1: go to LOW; remaining is untouched.
- The half-period counter reloads from the live DIV register at each phase entry. A DIV write mid-burst affects the next phase only.
- Clearing free_run while active: the FSM finishes the current half-period, then goes to IDLE. done is not set.
- COUNT write N≠0 while busy: reloads remaining; the phase and counter are undisturbed.
- COUNT write 0 while busy: IDLE on the next cycle. done is not set and remaining becomes 0.
- Setting free_run while a burst is active converts it to free-run; remaining freezes.
- A done set and a done-clear write in the same cycle: set wins.
- Reset mid-operation: all registers, the FSM and out_port clear immediately. out_port=0 and IDLE.
- Reset values: out_port=0, busy=0, irq=0, readdata reflects the reset registers (all 0).

## Timing
- Write at cycle T starts activity: state LOW and out_port=0 from T+1.
- First rising edge at T+1+(DIV+1).
- Period is 2·(DIV+1) clk cycles with 50 % duty. DIV=0 gives clk/2.
- Last pulse: out_port returns to level on the cycle after the final HIGH phase expires; done and irq go high on that same cycle.
- busy is registered and equals (state≠IDLE).
- CTRL.level writes while idle appear on out_port at T+1.
- Reads are combinational from current register state. A read and a write in the same cycle return the pre-write value.

## Structure
- Package `sd_clk_gen_pkg` holds:
  - register address constants (CTRL=0, DIV=1, COUNT=2, STATUS=3);
  - CTRL/STATUS bit-position constants;
  - the FSM state enum {IDLE, LOW, HIGH}.
- Sub-module `sd_clk_gen_div` is a DIV_W-bit half-period down-counter with `load`, `load_val` and `expire` ports. `expire` is high when the counter is 0.
- The top level holds the register file, the FSM and the remaining counter.

## Test plan
- Reset, then read all four registers: each reads 0, out_port=0, irq=0. Write CTRL=1: out_port=1 at T+1.
- DIV=2, COUNT=3:
  - exactly 3 rising edges, each high for 3 cycles and low for 3 cycles;
  - done=1 and busy=0 at T+1+18;
  - COUNT reads 2 after the first high phase.
- DIV=0 and CTRL=0b110: free-run at clk/2 with irq never set. Clear free_run: IDLE within ≤1 half-period and done stays 0.
- Abort: COUNT=10 with DIV=4. Write COUNT=0 in the middle of the 3rd pulse: out_port=level and busy=0 next cycle, done=0.
- Mid-burst changes:
  - Write DIV=1 during a high phase: the next low phase lasts 2 cycles.
  - Write COUNT=5 with 2 remaining: 5 more pulses follow, with no phase glitch.
- Assert reset_n low asynchronously mid-HIGH: out_port=0 immediately, busy=0. After release, a fresh COUNT=1 produces exactly one pulse.

Source files
------------

// File: rtl/sd_clk_gen_pkg.sv
// Shared constants and state type for the SD clock generator.
package sd_clk_gen_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DIV    = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int unsigned CTRL_LEVEL    = 0;
  localparam int unsigned CTRL_FREE_RUN = 1;
  localparam int unsigned CTRL_IRQ_EN   = 2;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_e;

endpackage

// File: rtl/sd_clk_gen_div.sv
// Half-period down-counter: reloads on load, counts to 0 and holds there.
module sd_clk_gen_div #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  output logic             expire
);

  logic [DIV_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign expire = (r_cnt == '0);

endmodule

// File: rtl/sd_clk_gen.sv
// Avalon-MM SD clock generator: register file, phase FSM and burst pulse counter.
module sd_clk_gen
  import sd_clk_gen_pkg::*;
#(
  parameter int unsigned DIV_W = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        out_port,
  output logic        busy,
  output logic        irq
);

  state_e           r_state, w_state_next;
  logic [2:0]       r_ctrl, w_ctrl_next;
  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_remaining;
  logic             r_done, r_fr_mode, r_busy, r_out;
  logic             w_out_next, w_load, w_expire, w_dec, w_burst_end;
  logic             w_wr, w_wr_ctrl, w_wr_div, w_wr_count, w_wr_status;
  logic             w_count_nz, w_free_run;
  logic [CNT_W-1:0] w_count_val;
  logic             w_unused;

  assign w_wr        = chipselect && !write_n;
  assign w_wr_ctrl   = w_wr && (address == ADDR_CTRL);
  assign w_wr_div    = w_wr && (address == ADDR_DIV);
  assign w_wr_count  = w_wr && (address == ADDR_COUNT);
  assign w_wr_status = w_wr && (address == ADDR_STATUS);
  assign w_count_val = writedata[CNT_W-1:0];
  assign w_count_nz  = (w_count_val != '0);
  assign w_unused    = ^writedata;

  // Next CTRL value is used so a CTRL write takes effect on the following cycle.
  assign w_ctrl_next = w_wr_ctrl ? writedata[2:0] : r_ctrl;
  assign w_free_run  = w_ctrl_next[CTRL_FREE_RUN];

  sd_clk_gen_div #(
    .DIV_W(DIV_W)
  ) u_div (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (w_load),
    .load_val(r_div),
    .expire  (w_expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_dec        = 1'b0;
    w_burst_end  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if ((w_wr_count && w_count_nz) || w_free_run) w_state_next = LOW;
      end
      LOW: begin
        if (w_expire) w_state_next = (!w_free_run && r_fr_mode) ? IDLE : HIGH;
      end
      HIGH: begin
        if (w_expire) begin
          if (w_free_run) begin
            w_state_next = LOW;
          end else if (r_fr_mode) begin
            w_state_next = IDLE;
          end else if (w_wr_count) begin
            w_state_next = LOW;
          end else if (r_remaining <= CNT_W'(1)) begin
            w_state_next = IDLE;
            w_dec        = 1'b1;
            w_burst_end  = 1'b1;
          end else begin
            w_state_next = LOW;
            w_dec        = 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (w_wr_count && !w_count_nz) w_state_next = IDLE;
  end

  always_comb begin
    w_out_next = (w_state_next == HIGH) ||
                 ((w_state_next == IDLE) && w_ctrl_next[CTRL_LEVEL]);
    w_load     = (w_state_next != IDLE) && (w_state_next != r_state);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctrl      <= '0;
      r_div       <= '0;
      r_remaining <= '0;
      r_done      <= 1'b0;
      r_fr_mode   <= 1'b0;
      r_busy      <= 1'b0;
      r_out       <= 1'b0;
    end else begin
      r_ctrl    <= w_ctrl_next;
      r_busy    <= (w_state_next != IDLE);
      r_out     <= w_out_next;
      // Once free-run has been seen during activity, clearing it ends activity.
      r_fr_mode <= (w_state_next != IDLE) && (r_fr_mode || w_free_run);
      if (w_wr_div) r_div <= writedata[DIV_W-1:0];
      if (w_wr_count) begin
        r_remaining <= w_count_val;
      end else if (w_dec) begin
        r_remaining <= r_remaining - 1'b1;
      end
      if (w_burst_end) begin
        r_done <= 1'b1;
      end else if (w_wr_status && writedata[STAT_DONE]) begin
        r_done <= 1'b0;
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL:   readdata[2:0]       = r_ctrl;
      ADDR_DIV:    readdata[DIV_W-1:0] = r_div;
      ADDR_COUNT:  readdata[CNT_W-1:0] = r_remaining;
      ADDR_STATUS: begin
        readdata[STAT_BUSY] = r_busy;
        readdata[STAT_DONE] = r_done;
      end
      default:     readdata = '0;
    endcase
  end

  assign out_port = r_out;
  assign busy     = r_busy;
  assign irq      = r_done && r_ctrl[CTRL_IRQ_EN];

endmodule

// File: tb/tb_sd_clk_gen.sv
// Directed bench for sd_clk_gen: bursts, free-run, abort, mid-burst edits, async reset.
module tb_sd_clk_gen;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        out_port, busy, irq;

  int n_vec = 0;
  int n_err = 0;

  sd_clk_gen #(
    .DIV_W(16),
    .CNT_W(16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port),
    .busy      (busy),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), d);
      n_vec++;
      if (d !== 32'd0) begin
        n_err++; $display("FAIL reset_reg%0d: got %0h want 0", a, d);
      end
    end
    n_vec++;
    if (out_port !== 1'b0) begin n_err++; $display("FAIL reset_out: got %b want 0", out_port); end
    n_vec++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_level;
    bus_write(2'd0, 32'd1);
    n_vec++;
    if (out_port !== 1'b1) begin n_err++; $display("FAIL level_hi: got %b want 1", out_port); end
    bus_write(2'd0, 32'd0);
    n_vec++;
    if (out_port !== 1'b0) begin n_err++; $display("FAIL level_lo: got %b want 0", out_port); end
  endtask

  task automatic test_burst;
    logic [31:0] d;
    logic exp, prev;
    int edges;
    bus_write(2'd1, 32'd2);
    bus_write(2'd2, 32'd3);
    address = 2'd2;
    prev = 1'b0; edges = 0;
    for (int k = 0; k < 18; k++) begin
      if (k != 0) @(negedge clk);
      exp = ((k % 6) >= 3);
      n_vec++;
      if (out_port !== exp) begin
        n_err++; $display("FAIL burst_wave k=%0d: got %b want %b", k, out_port, exp);
      end
      if (out_port === 1'b1 && prev === 1'b0) edges++;
      prev = out_port;
      if (k == 0 || k == 6) begin
        bus_read(2'd2, d);
        n_vec++;
        if (d !== ((k == 0) ? 32'd3 : 32'd2)) begin
          n_err++; $display("FAIL burst_count k=%0d: got %0d", k, d);
        end
      end
      if (k == 0) begin
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL burst_busy: got %b want 1", busy); end
      end
    end
    @(negedge clk);
    n_vec++;
    if (edges != 3) begin n_err++; $display("FAIL burst_edges: got %0d want 3", edges); end
    bus_read(2'd3, d);
    n_vec++;
    if (d !== 32'd2) begin n_err++; $display("FAIL burst_status: got %0h want 2", d); end
    n_vec++;
    if (out_port !== 1'b0 || irq !== 1'b0) begin
      n_err++; $display("FAIL burst_end_out_irq: got %b%b want 00", out_port, irq);
    end
    bus_write(2'd3, 32'd2);
    bus_read(2'd3, d);
    n_vec++;
    if (d !== 32'd0) begin n_err++; $display("FAIL done_clear: got %0h want 0", d); end
  endtask

  task automatic test_free_run;
    logic [31:0] d;
    bus_write(2'd1, 32'd0);
    bus_write(2'd0, 32'd6);
    for (int k = 0; k < 8; k++) begin
      if (k != 0) @(negedge clk);
      n_vec++;
      if (out_port !== 1'(k % 2) || irq !== 1'b0) begin
        n_err++; $display("FAIL freerun k=%0d: got out=%b irq=%b want out=%0d irq=0",
                          k, out_port, irq, k % 2);
      end
    end
    bus_write(2'd0, 32'd4);
    bus_read(2'd3, d);
    n_vec++;
    if (d !== 32'd0 || out_port !== 1'b0 || irq !== 1'b0) begin
      n_err++; $display("FAIL freerun_stop: got status=%0h out=%b irq=%b want 0 0 0",
                        d, out_port, irq);
    end
  endtask

  task automatic test_abort;
    logic [31:0] d;
    bus_write(2'd0, 32'd5);
    bus_write(2'd1, 32'd4);
    bus_write(2'd2, 32'd10);
    repeat (26) @(negedge clk);
    n_vec++;
    if (out_port !== 1'b1) begin n_err++; $display("FAIL abort_pre: got %b want 1", out_port); end
    bus_write(2'd2, 32'd0);
    n_vec++;
    if (out_port !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL abort_idle: got out=%b busy=%b want 1 0", out_port, busy);
    end
    bus_read(2'd3, d);
    n_vec++;
    if (d !== 32'd0 || irq !== 1'b0) begin
      n_err++; $display("FAIL abort_done: got status=%0h irq=%b want 0 0", d, irq);
    end
    bus_read(2'd2, d);
    n_vec++;
    if (d !== 32'd0) begin n_err++; $display("FAIL abort_count: got %0d want 0", d); end
    bus_write(2'd0, 32'd0);
  endtask

  task automatic test_mid_div;
    logic [31:0] d;
    logic exp_w [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    bus_write(2'd1, 32'd2);
    bus_write(2'd2, 32'd4);
    repeat (3) @(negedge clk);
    bus_write(2'd1, 32'd1);
    for (int i = 0; i < 6; i++) begin
      if (i != 0) @(negedge clk);
      n_vec++;
      if (out_port !== exp_w[i]) begin
        n_err++; $display("FAIL middiv k=%0d: got %b want %b", i + 5, out_port, exp_w[i]);
      end
    end
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    bus_read(2'd3, d);
    n_vec++;
    if (d !== 32'd2) begin n_err++; $display("FAIL middiv_end: got %0h want 2", d); end
    bus_write(2'd3, 32'd2);
  endtask

  task automatic test_mid_count;
    logic [31:0] d;
    logic prev;
    int edges;
    bus_write(2'd1, 32'd1);
    bus_write(2'd2, 32'd3);
    repeat (4) @(negedge clk);
    bus_read(2'd2, d);
    n_vec++;
    if (d !== 32'd2) begin n_err++; $display("FAIL midcnt_rem: got %0d want 2", d); end
    bus_write(2'd2, 32'd5);
    prev = 1'b0; edges = 0;
    for (int k = 6; k < 24; k++) begin
      if (k != 6) @(negedge clk);
      n_vec++;
      if (out_port !== ((k % 4) >= 2)) begin
        n_err++; $display("FAIL midcnt_wave k=%0d: got %b want %b", k, out_port, (k % 4) >= 2);
      end
      if (out_port === 1'b1 && prev === 1'b0) edges++;
      prev = out_port;
    end
    @(negedge clk);
    n_vec++;
    if (edges != 5) begin n_err++; $display("FAIL midcnt_edges: got %0d want 5", edges); end
    n_vec++;
    if (busy !== 1'b0 || out_port !== 1'b0) begin
      n_err++; $display("FAIL midcnt_end: got busy=%b out=%b want 0 0", busy, out_port);
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] d;
    logic prev;
    int edges;
    bus_write(2'd1, 32'd3);
    bus_write(2'd2, 32'd2);
    repeat (5) @(negedge clk);
    n_vec++;
    if (out_port !== 1'b1) begin n_err++; $display("FAIL rst_pre: got %b want 1", out_port); end
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if (out_port !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rst_async: got out=%b busy=%b want 0 0", out_port, busy);
    end
    bus_read(2'd1, d);
    n_vec++;
    if (d !== 32'd0) begin n_err++; $display("FAIL rst_div: got %0h want 0", d); end
    @(negedge clk);
    reset_n = 1'b1;
    bus_write(2'd2, 32'd1);
    prev = 1'b0; edges = 0;
    for (int k = 0; k < 6; k++) begin
      if (k != 0) @(negedge clk);
      if (out_port === 1'b1 && prev === 1'b0) edges++;
      prev = out_port;
    end
    n_vec++;
    if (edges != 1) begin n_err++; $display("FAIL rst_pulse: got %0d edges want 1", edges); end
    bus_read(2'd3, d);
    n_vec++;
    if (d !== 32'd2) begin n_err++; $display("FAIL rst_status: got %0h want 2", d); end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_level();
    test_burst();
    test_free_run();
    test_abort();
    test_mid_div();
    test_mid_count();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
